// File: rtl/adc_snapshot_capture.sv
// adc_snapshot_capture
//   Pre/post-trigger snapshot capture for one ADC channel. Each clock delivers a
//   24-bit word holding two 12-bit two's-complement samples (rise = older,
//   fall = newer). After arming, the block fills a circular block RAM, waits for
//   a level/slope crossing (or a forced trigger), finishes the post-trigger part
//   of the window and then streams the DEPTH-word window out on valid/ready.
//
// Ports
//   adc_clk_i, rst_i        : sole clock; asynchronous active-high reset
//   data_i                  : {fall sample, rise sample}
//   arm_i, abort_i          : start a capture / return to IDLE from anywhere
//   force_trig_i            : unconditional trigger while waiting
//   trig_level_i, trig_slope_i, pre_trig_i : trigger setup (pre sampled on arm)
//   state_o, post_o         : 0 IDLE, 1 PRE, 2 WAIT/POST, 3 READOUT; post_o = POST
//   trig_phase_o, trig_forced_o : which sample triggered / forced trigger flag
//   done_o                  : one-cycle pulse after the last word is accepted
//   rd_data_o, rd_valid_o, rd_ready_i, rd_last_o : window readout stream
//   trig_ts_o               : trigger timestamp (only with ADC_SNAPSHOT_TIMESTAMP_EN)
//
// Optional feature macro: ADC_SNAPSHOT_TIMESTAMP_EN
//   Adds a free-running 32-bit cycle counter whose value is latched into
//   trig_ts_o on every trigger cycle.
module adc_snapshot_capture #(
  parameter int ADDR_W   = 10,
  parameter int SAMPLE_W = 12
) (
  input  logic                  adc_clk_i,
  input  logic                  rst_i,
  input  logic [2*SAMPLE_W-1:0] data_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic                  force_trig_i,
  input  logic [SAMPLE_W-1:0]   trig_level_i,
  input  logic                  trig_slope_i,
  input  logic [ADDR_W-1:0]     pre_trig_i,
  output logic [1:0]            state_o,
  output logic                  post_o,
  output logic                  trig_phase_o,
  output logic                  trig_forced_o,
  output logic                  done_o,
  output logic [2*SAMPLE_W-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  rd_last_o
`ifdef ADC_SNAPSHOT_TIMESTAMP_EN
  ,
  output logic [31:0]           trig_ts_o
`endif
);

  localparam int DW    = 2 * SAMPLE_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_READ = 3'd4
  } state_t;

  state_t                state_r, state_next_s;
  logic [1:0]            state_code_s;
  logic [DW-1:0]         s1_r;
  logic [SAMPLE_W-1:0]   prev_fall_r;
  logic [ADDR_W-1:0]     wr_ptr_r, pre_r, pre_left_r, post_left_r, rd_addr_r;
  logic [ADDR_W:0]       rd_cnt_r;
  logic [DW-1:0]         mem_r [DEPTH];
  logic [DW-1:0]         ram_q_r, skid_data_r;
  logic                  ram_vld_r, ram_last_r, skid_vld_r, skid_last_r;
  logic                  wr_en_s, arm_fire_s, trig_fire_s, done_fire_s;
  logic                  p0_s, p1_s, nat_s, pop_s, issue_s;
  logic [2:0]            occ_s;

  logic signed [SAMPLE_W-1:0] rise_s, fall_s, pfall_s, lvl_s;
  assign rise_s  = s1_r[SAMPLE_W-1:0];
  assign fall_s  = s1_r[DW-1:SAMPLE_W];
  assign pfall_s = prev_fall_r;
  assign lvl_s   = trig_level_i;

  // Trigger comparators: phase 0 crosses between the previous fall sample and
  // this rise sample, phase 1 crosses inside the current word.
  always_comb begin
    p0_s = 1'b0;
    p1_s = 1'b0;
    if (trig_slope_i) begin
      p0_s = (pfall_s > lvl_s) && (rise_s <= lvl_s);
      p1_s = (rise_s > lvl_s) && (fall_s <= lvl_s);
    end else begin
      p0_s = (pfall_s < lvl_s) && (rise_s >= lvl_s);
      p1_s = (rise_s < lvl_s) && (fall_s >= lvl_s);
    end
  end

  assign nat_s = p0_s | p1_s;
  assign pop_s = rd_valid_o & rd_ready_i;

  // Words held in the output pair plus the one in flight from the RAM; a new
  // read is issued only if it is guaranteed a slot when it lands.
  assign occ_s   = {2'b00, rd_valid_o} + {2'b00, skid_vld_r} + {2'b00, ram_vld_r};
  assign issue_s = (state_r == ST_READ) && !abort_i && (rd_cnt_r != CNT_FULL) &&
                   (occ_s <= ({2'b00, pop_s} + 3'd1));

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    state_next_s = state_r;
    wr_en_s      = 1'b0;
    arm_fire_s   = 1'b0;
    trig_fire_s  = 1'b0;
    done_fire_s  = 1'b0;
    if (abort_i) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arm_i) begin
            arm_fire_s = 1'b1;
            if (pre_trig_i == IDX_ZERO) begin
              state_next_s = ST_WAIT;
            end else begin
              state_next_s = ST_PRE;
            end
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_PRE: begin
          wr_en_s = 1'b1;
          if (pre_left_r == IDX_ONE) begin
            state_next_s = ST_WAIT;
          end else begin
            state_next_s = ST_PRE;
          end
        end
        ST_WAIT: begin
          wr_en_s = 1'b1;
          if (nat_s || force_trig_i) begin
            trig_fire_s  = 1'b1;
            state_next_s = ST_POST;
          end else begin
            state_next_s = ST_WAIT;
          end
        end
        ST_POST: begin
          // With pre = DEPTH-1 the trigger word completes the window, so POST
          // must not write at all.
          wr_en_s = (post_left_r != IDX_ZERO);
          if (post_left_r <= IDX_ONE) begin
            state_next_s = ST_READ;
          end else begin
            state_next_s = ST_POST;
          end
        end
        ST_READ: begin
          if (pop_s && rd_last_o) begin
            done_fire_s  = 1'b1;
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_READ;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // External state code for the next state, so state_o comes straight from a flop.
  always_comb begin
    state_code_s = 2'd0;
    case (state_next_s)
      ST_IDLE: state_code_s = 2'd0;
      ST_PRE:  state_code_s = 2'd1;
      ST_WAIT: state_code_s = 2'd2;
      ST_POST: state_code_s = 2'd2;
      ST_READ: state_code_s = 2'd3;
      default: state_code_s = 2'd0;
    endcase
  end

  // FSM state register and registered status outputs.
  always_ff @(posedge adc_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      state_o <= 2'd0;
      post_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      state_o <= state_code_s;
      post_o  <= (state_next_s == ST_POST);
      done_o  <= done_fire_s;
    end
  end

  // Input stage, previous fall sample, window counters and read addressing.
  always_ff @(posedge adc_clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_r          <= {DW{1'b0}};
      prev_fall_r   <= {SAMPLE_W{1'b0}};
      wr_ptr_r      <= IDX_ZERO;
      pre_r         <= IDX_ZERO;
      pre_left_r    <= IDX_ZERO;
      post_left_r   <= IDX_ZERO;
      rd_addr_r     <= IDX_ZERO;
      rd_cnt_r      <= {(ADDR_W+1){1'b0}};
      trig_phase_o  <= 1'b0;
      trig_forced_o <= 1'b0;
    end else begin
      s1_r <= data_i;
      if (arm_fire_s) begin
        prev_fall_r <= {SAMPLE_W{1'b0}};
      end else begin
        prev_fall_r <= s1_r[DW-1:SAMPLE_W];
      end
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + IDX_ONE;
      end
      // pre_trig_i is ADDR_W bits wide, so it can never exceed DEPTH-1.
      if (arm_fire_s) begin
        pre_r      <= pre_trig_i;
        pre_left_r <= pre_trig_i;
      end else if (wr_en_s && (state_r == ST_PRE)) begin
        pre_left_r <= pre_left_r - IDX_ONE;
      end
      if (trig_fire_s) begin
        // The trigger word itself is the first of the DEPTH-pre post words.
        post_left_r   <= IDX_LAST - pre_r;
        rd_addr_r     <= wr_ptr_r - pre_r;
        rd_cnt_r      <= {(ADDR_W+1){1'b0}};
        trig_phase_o  <= nat_s & ~p0_s;
        trig_forced_o <= ~nat_s;
      end else begin
        if (wr_en_s && (state_r == ST_POST)) begin
          post_left_r <= post_left_r - IDX_ONE;
        end
        if (issue_s) begin
          rd_addr_r <= rd_addr_r + IDX_ONE;
          rd_cnt_r  <= rd_cnt_r + CNT_ONE;
        end
      end
    end
  end

  // Capture buffer: one write port, registered read port, no reset so it maps to block RAM.
  always_ff @(posedge adc_clk_i) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= s1_r;
    end
    ram_q_r <= mem_r[rd_addr_r];
  end

  // Tracks whether the RAM output register holds a requested word, and if it is the final one.
  always_ff @(posedge adc_clk_i or posedge rst_i) begin
    if (rst_i) begin
      ram_vld_r  <= 1'b0;
      ram_last_r <= 1'b0;
    end else if (abort_i) begin
      ram_vld_r  <= 1'b0;
      ram_last_r <= 1'b0;
    end else begin
      ram_vld_r  <= issue_s;
      ram_last_r <= issue_s && (rd_cnt_r == {1'b0, IDX_LAST});
    end
  end

  // Two-entry skid buffer; the head entry is the registered stream output.
  always_ff @(posedge adc_clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_o  <= 1'b0;
      rd_data_o   <= {DW{1'b0}};
      rd_last_o   <= 1'b0;
      skid_vld_r  <= 1'b0;
      skid_data_r <= {DW{1'b0}};
      skid_last_r <= 1'b0;
    end else if (abort_i) begin
      rd_valid_o <= 1'b0;
      rd_last_o  <= 1'b0;
      skid_vld_r <= 1'b0;
    end else if (!rd_valid_o || pop_s) begin
      if (skid_vld_r) begin
        rd_valid_o  <= 1'b1;
        rd_data_o   <= skid_data_r;
        rd_last_o   <= skid_last_r;
        skid_vld_r  <= ram_vld_r;
        skid_data_r <= ram_q_r;
        skid_last_r <= ram_last_r;
      end else begin
        rd_valid_o <= ram_vld_r;
        skid_vld_r <= 1'b0;
        if (ram_vld_r) begin
          rd_data_o <= ram_q_r;
          rd_last_o <= ram_last_r;
        end else begin
          rd_last_o <= 1'b0;
        end
      end
    end else if (ram_vld_r) begin
      // Head is stalled: park the arriving word; flow control keeps this slot free.
      skid_vld_r  <= 1'b1;
      skid_data_r <= ram_q_r;
      skid_last_r <= ram_last_r;
    end
  end

`ifdef ADC_SNAPSHOT_TIMESTAMP_EN
  logic [31:0] ts_cnt_r;

  // Free-running cycle counter and the timestamp captured on each trigger.
  always_ff @(posedge adc_clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_cnt_r  <= 32'd0;
      trig_ts_o <= 32'd0;
    end else begin
      ts_cnt_r <= ts_cnt_r + 32'd1;
      if (trig_fire_s) begin
        trig_ts_o <= ts_cnt_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_snapshot_capture.sv
// Self-checking bench for adc_snapshot_capture: expected window words are queued
// when a capture is armed and popped on every stream handshake.
module tb_adc_snapshot_capture;
  localparam int ADDR_W   = 10;
  localparam int SAMPLE_W = 12;
  localparam int DEPTH    = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] data_i;
  logic        arm_i, abort_i, force_trig_i, trig_slope_i, rd_ready_i;
  logic [11:0] trig_level_i;
  logic [9:0]  pre_trig_i;
  logic [1:0]  state_o;
  logic        post_o, trig_phase_o, trig_forced_o, done_o, rd_valid_o, rd_last_o;
  logic [23:0] rd_data_o;
`ifdef ADC_SNAPSHOT_TIMESTAMP_EN
  logic [31:0] trig_ts_o;
`endif

  always #5 clk = ~clk;

  adc_snapshot_capture #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) dut (
    .adc_clk_i     (clk),
    .rst_i         (rst),
    .data_i        (data_i),
    .arm_i         (arm_i),
    .abort_i       (abort_i),
    .force_trig_i  (force_trig_i),
    .trig_level_i  (trig_level_i),
    .trig_slope_i  (trig_slope_i),
    .pre_trig_i    (pre_trig_i),
    .state_o       (state_o),
    .post_o        (post_o),
    .trig_phase_o  (trig_phase_o),
    .trig_forced_o (trig_forced_o),
    .done_o        (done_o),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .rd_ready_i    (rd_ready_i),
    .rd_last_o     (rd_last_o)
`ifdef ADC_SNAPSHOT_TIMESTAMP_EN
    ,
    .trig_ts_o     (trig_ts_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stimulus word n after arming: mode 0 = ramp (rise 2n, fall 2n+1),
  // mode 1 = descending negative values starting at -200 (never crosses 0).
  int k;
  int mode;
  bit rand_ready;

  function automatic logic [23:0] word_at(input int n, input int m);
    logic [11:0] r, f;
    if (m == 0) begin
      r = 12'(2 * n);
      f = 12'(2 * n + 1);
    end else begin
      r = 12'(-200 - n);
      f = r;
    end
    return {f, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    data_i     = word_at(k, mode);
    rd_ready_i = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
  endtask

  task automatic arm(input int m, input logic [11:0] lvl, input logic slope, input logic [9:0] pre);
    mode         = m;
    trig_level_i = lvl;
    trig_slope_i = slope;
    pre_trig_i   = pre;
    k            = 0;
    data_i       = word_at(0, m);
    arm_i        = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  // Scoreboard and stream monitor.
  logic [23:0] exp_q[$];
  bit          mon_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [24:0] held;
  int          hs_cnt = 0;
  int          done_cnt = 0;

  task automatic push_window(input int m, input int first);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(word_at(first + i, m));
  endtask

  always @(negedge clk) begin
    logic [23:0] e;
    if (!mon_en) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev)
        check_eq("stall_hold", {7'd0, rd_valid_o, rd_last_o, rd_data_o}, {7'd0, 1'b1, held});
      if (rd_valid_o && rd_ready_i) begin
        check_eq("q_avail", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("rd_data", {8'd0, rd_data_o}, {8'd0, e});
          check_eq("rd_last", {31'd0, rd_last_o}, 32'(exp_q.size() == 0));
        end
        hs_cnt <= hs_cnt + 1;
      end
      if (done_o) done_cnt <= done_cnt + 1;
      stall_prev <= rd_valid_o && !rd_ready_i;
      held       <= {rd_last_o, rd_data_o};
    end
  end

  task automatic wait_done(input string tag, input int hs0, input int d0);
    int budget = 6000;
    while (done_cnt == d0 && budget > 0) begin
      tick();
      budget--;
    end
    check_eq({tag, "_done_timeout"}, 32'(budget > 0), 32'd1);
    tick();
    tick();
    check_eq({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, "_handshakes"}, 32'(hs_cnt - hs0), 32'(DEPTH));
    check_eq({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_idle_after"}, {30'd0, state_o}, 32'd0);
    check_eq({tag, "_valid_after"}, {31'd0, rd_valid_o}, 32'd0);
  endtask

  initial begin
    int hs0, d0, lat, budget, spurious;
    rst = 1'b1; data_i = 24'd0; arm_i = 1'b0; abort_i = 1'b0; force_trig_i = 1'b0;
    trig_level_i = 12'd0; trig_slope_i = 1'b0; pre_trig_i = 10'd0; rd_ready_i = 1'b1;
    k = 0; mode = 0; rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", {30'd0, state_o}, 32'd0);
    check_eq("rst_post", {31'd0, post_o}, 32'd0);
    check_eq("rst_valid", {31'd0, rd_valid_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_last", {31'd0, rd_last_o}, 32'd0);
    check_eq("rst_data", {8'd0, rd_data_o}, 32'd0);
    check_eq("rst_phase", {31'd0, trig_phase_o}, 32'd0);
    check_eq("rst_forced", {31'd0, trig_forced_o}, 32'd0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // T1: ramp, level 100, rising, pre 16 -> trigger word 50, window 34..1057.
    hs0 = hs_cnt; d0 = done_cnt;
    push_window(0, 34);
    arm(0, 12'd100, 1'b0, 10'd16);
    check_eq("t1_pre", {30'd0, state_o}, 32'd1);
    while (k < 16) tick();
    check_eq("t1_last_pre", {30'd0, state_o}, 32'd1);
    tick();
    check_eq("t1_wait", {30'd0, state_o}, 32'd2);
    check_eq("t1_wait_post", {31'd0, post_o}, 32'd0);
    while (k < 51) tick();
    check_eq("t1_trig_cycle_post", {31'd0, post_o}, 32'd0);
    tick();
    check_eq("t1_post", {31'd0, post_o}, 32'd1);
    check_eq("t1_post_state", {30'd0, state_o}, 32'd2);
    budget = 2000;
    while (state_o != 2'd3 && budget > 0) begin tick(); budget--; end
    check_eq("t1_readout_reached", 32'(budget > 0), 32'd1);
    lat = 0;
    while (!rd_valid_o && lat < 6) begin tick(); lat++; end
    check_eq("t1_first_valid_lat", 32'(lat <= 3), 32'd1);
    wait_done("t1", hs0, d0);
    check_eq("t1_phase", {31'd0, trig_phase_o}, 32'd0);
    check_eq("t1_forced", {31'd0, trig_forced_o}, 32'd0);

    // T2: level 101 -> phase 1 on word 50; 30% backpressure on the stream.
    hs0 = hs_cnt; d0 = done_cnt;
    push_window(0, 34);
    rand_ready = 1'b1;
    arm(0, 12'd101, 1'b0, 10'd16);
    wait_done("t2", hs0, d0);
    check_eq("t2_phase", {31'd0, trig_phase_o}, 32'd1);
    check_eq("t2_forced", {31'd0, trig_forced_o}, 32'd0);

    // T3: negative input, pre 0, force 40 cycles after arm; the word written
    // in the force cycle is the one registered from the previous cycle (39).
    hs0 = hs_cnt; d0 = done_cnt;
    push_window(1, 39);
    arm(1, 12'd0, 1'b0, 10'd0);
    check_eq("t3_wait_direct", {30'd0, state_o}, 32'd2);
    while (k < 40) tick();
    force_trig_i = 1'b1;
    tick();
    force_trig_i = 1'b0;
    check_eq("t3_post", {31'd0, post_o}, 32'd1);
    wait_done("t3", hs0, d0);
    check_eq("t3_forced", {31'd0, trig_forced_o}, 32'd1);
    check_eq("t3_phase", {31'd0, trig_phase_o}, 32'd0);

    // T4: abort in POST, immediate re-arm with pre 1023.
    rand_ready = 1'b0;
    arm(1, 12'd0, 1'b0, 10'd0);
    while (k < 10) tick();
    force_trig_i = 1'b1;
    tick();
    force_trig_i = 1'b0;
    check_eq("t4_in_post", {31'd0, post_o}, 32'd1);
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_eq("t4_abort_idle", {30'd0, state_o}, 32'd0);
    check_eq("t4_abort_post", {31'd0, post_o}, 32'd0);
    hs0 = hs_cnt; d0 = done_cnt;
    push_window(1, 0);
    arm(1, 12'd0, 1'b0, 10'd1023);
    check_eq("t4_rearm_pre", {30'd0, state_o}, 32'd1);
    check_eq("t4_rearm_valid", {31'd0, rd_valid_o}, 32'd0);
    spurious = 0;
    while (k < 1023) begin
      tick();
      if (rd_valid_o) spurious++;
    end
    check_eq("t4_no_spurious_valid", 32'(spurious), 32'd0);
    check_eq("t4_last_pre", {30'd0, state_o}, 32'd1);
    tick();
    check_eq("t4_wait", {30'd0, state_o}, 32'd2);
    force_trig_i = 1'b1;
    tick();
    force_trig_i = 1'b0;
    check_eq("t4_post", {31'd0, post_o}, 32'd1);
    wait_done("t4", hs0, d0);
    check_eq("t4_forced", {31'd0, trig_forced_o}, 32'd1);

    // T5: asynchronous reset in the middle of readout.
    hs0 = hs_cnt;
    rand_ready = 1'b1;
    push_window(0, 34);
    arm(0, 12'd100, 1'b0, 10'd16);
    budget = 4000;
    while ((hs_cnt - hs0 < 100 || !rd_valid_o) && budget > 0) begin tick(); budget--; end
    check_eq("t5_mid_readout", 32'(budget > 0 && state_o == 2'd3), 32'd1);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_rst_valid", {31'd0, rd_valid_o}, 32'd0);
    check_eq("t5_rst_state", {30'd0, state_o}, 32'd0);
    exp_q.delete();
    tick();
    tick();
    #2;
    rst = 1'b0;
    tick();
    check_eq("t5_after_state", {30'd0, state_o}, 32'd0);
    check_eq("t5_after_valid", {31'd0, rd_valid_o}, 32'd0);
    check_eq("t5_after_phase", {31'd0, trig_phase_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
